// File: rtl/counter_capture_arb_pkg.sv
// Shared types and constants for the capture-drain scheduler (package counter_pkg).
// Optional feature macro: COUNTER_CAPARB_TIMESTAMP_EN (grant timestamp on each record).
package counter_pkg;

    localparam int SLOTS_PER_CNT = 6;
    localparam int DATA_W        = 32;

    typedef enum logic [2:0] {
        SLOT_A0 = 3'd0,
        SLOT_A1 = 3'd1,
        SLOT_A2 = 3'd2,
        SLOT_B0 = 3'd3,
        SLOT_B1 = 3'd4,
        SLOT_B2 = 3'd5
    } slot_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_capture_arb_if.sv
// Record stream from the capture scheduler toward readback/DMA logic.
// Carries rec_timestamp only when COUNTER_CAPARB_TIMESTAMP_EN is defined.
interface counter_capture_arb_if
    import counter_pkg::*;
#(
    parameter int COUNTER_NUM = 4
);
    localparam int IDX_W = idx_width(COUNTER_NUM);

    logic              rec_valid;
    logic              rec_ready;
    logic [IDX_W-1:0]  rec_cnt_idx;
    logic [2:0]        rec_slot;
    logic [DATA_W-1:0] rec_data;
`ifdef COUNTER_CAPARB_TIMESTAMP_EN
    logic [31:0]       rec_timestamp;
`endif

    modport master (
        output rec_valid,
        output rec_cnt_idx,
        output rec_slot,
        output rec_data,
`ifdef COUNTER_CAPARB_TIMESTAMP_EN
        output rec_timestamp,
`endif
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_cnt_idx,
        input  rec_slot,
        input  rec_data,
`ifdef COUNTER_CAPARB_TIMESTAMP_EN
        input  rec_timestamp,
`endif
        output rec_ready
    );

endinterface

// File: rtl/counter_capture_arb_rr_arb.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping
// at REQ_NUM-1 back to 0.
module counter_rr_arb #(
    parameter  int REQ_NUM = 24,
    localparam int PTR_W   = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_any
);

    always_comb begin
        logic [PTR_W:0] v_pos;
        v_pos       = '0;
        o_any       = 1'b0;
        o_grant_idx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            // i_ptr < REQ_NUM, so a single subtract is enough to wrap
            v_pos = {1'b0, i_ptr} + (PTR_W + 1)'(i);
            if (v_pos >= (PTR_W + 1)'(REQ_NUM)) begin
                v_pos = v_pos - (PTR_W + 1)'(REQ_NUM);
            end
            if (!o_any && i_req[v_pos[PTR_W-1:0]]) begin
                o_any       = 1'b1;
                o_grant_idx = v_pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/counter_capture_arb.sv
// Drains pending capture slots one at a time onto a valid/ready record stream.
// Optional macro COUNTER_CAPARB_TIMESTAMP_EN adds a grant timestamp to each record.
//
// state   | meaning
// ST_IDLE | no record held; grant the next eligible slot when enabled
// ST_HOLD | record presented on the stream until the consumer takes it
module counter_capture_arb
    import counter_pkg::*;
#(
    parameter int COUNTER_NUM = 4
) (
    input  logic                                     i_pclk,
    input  logic                                     i_prst_n,
    input  logic                                     i_arb_en,
    input  logic [COUNTER_NUM*SLOTS_PER_CNT-1:0]        i_slot_mask,
    input  logic [COUNTER_NUM*SLOTS_PER_CNT-1:0]        i_capture_status,
    input  logic [COUNTER_NUM*SLOTS_PER_CNT*DATA_W-1:0] i_capture_data,
    output logic [COUNTER_NUM*SLOTS_PER_CNT-1:0]        o_read_flag,
    output logic                                     o_busy,
    counter_capture_arb_if.master                    rec_if
);

    localparam int REQ_NUM = COUNTER_NUM * SLOTS_PER_CNT;
    localparam int IDX_W   = idx_width(COUNTER_NUM);
    localparam int PTR_W   = $clog2(REQ_NUM);

    arb_state_e         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [REQ_NUM-1:0] r_blocked;
    logic [REQ_NUM-1:0] r_read_flag;
    logic               r_valid;
    logic [IDX_W-1:0]   r_cnt_idx;
    logic [2:0]         r_slot;
    logic [DATA_W-1:0]  r_data;
    logic               r_busy;

    logic [REQ_NUM-1:0] w_req;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_any;
    logic               w_grant_fire;
    logic [REQ_NUM-1:0] w_grant_onehot;
    logic [REQ_NUM-1:0] w_blocked_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   w_grant_cnt;
    logic [2:0]         w_grant_slot;
    logic [DATA_W-1:0]  w_grant_data;

    assign w_req = i_capture_status & i_slot_mask & ~r_blocked;

    counter_rr_arb #(
        .REQ_NUM (REQ_NUM)
    ) u_rr_arb (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_grant_fire   = (r_state == ST_IDLE) && i_arb_en && w_any;
    assign w_grant_onehot = w_grant_fire ? (REQ_NUM'(1) << w_grant_idx) : '0;
    // A slot stays blocked until its counter drops the status bit; a new grant wins
    assign w_blocked_nxt  = (r_blocked & i_capture_status) | w_grant_onehot;
    assign w_ptr_nxt      = (w_grant_idx == PTR_W'(REQ_NUM - 1)) ? '0
                                                                 : w_grant_idx + PTR_W'(1);
    assign w_grant_cnt    = IDX_W'(32'(w_grant_idx) / SLOTS_PER_CNT);
    assign w_grant_slot   = 3'(32'(w_grant_idx) % SLOTS_PER_CNT);
    assign w_grant_data   = i_capture_data[w_grant_idx*DATA_W +: DATA_W];

`ifdef COUNTER_CAPARB_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_rec_ts;

    always_ff @(posedge i_pclk or negedge i_prst_n) begin
        if (!i_prst_n) begin
            r_ts_cnt <= '0;
            r_rec_ts <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (w_grant_fire) begin
                r_rec_ts <= r_ts_cnt;
            end
        end
    end

    assign rec_if.rec_timestamp = r_rec_ts;
`endif

    always_ff @(posedge i_pclk or negedge i_prst_n) begin
        if (!i_prst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_blocked   <= '0;
            r_read_flag <= '0;
            r_valid     <= 1'b0;
            r_cnt_idx   <= '0;
            r_slot      <= '0;
            r_data      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_read_flag <= '0;
            r_blocked   <= w_blocked_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_fire) begin
                        r_state     <= ST_HOLD;
                        r_read_flag <= w_grant_onehot;
                        r_valid     <= 1'b1;
                        r_cnt_idx   <= w_grant_cnt;
                        r_slot      <= w_grant_slot;
                        r_data      <= w_grant_data;
                        r_ptr       <= w_ptr_nxt;
                        r_busy      <= 1'b1;
                    end else begin
                        r_busy      <= |w_blocked_nxt;
                    end
                end
                ST_HOLD: begin
                    if (rec_if.rec_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= |w_blocked_nxt;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_read_flag        = r_read_flag;
    assign o_busy             = r_busy;
    assign rec_if.rec_valid   = r_valid;
    assign rec_if.rec_cnt_idx = r_cnt_idx;
    assign rec_if.rec_slot    = r_slot;
    assign rec_if.rec_data    = r_data;

endmodule

// File: tb/tb_counter_capture_arb.sv
// Directed bench for counter_capture_arb (COUNTER_NUM=4); timestamp check only
// when COUNTER_CAPARB_TIMESTAMP_EN is defined.
module tb_counter_capture_arb;
    import counter_pkg::*;

    localparam int CN  = 4;
    localparam int RN  = CN * SLOTS_PER_CNT;

    logic                  i_pclk;
    logic                  i_prst_n;
    logic                  i_arb_en;
    logic [RN-1:0]         i_slot_mask;
    logic [RN-1:0]         i_capture_status;
    logic [RN*DATA_W-1:0]  i_capture_data;
    logic [RN-1:0]         o_read_flag;
    logic                  o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    counter_capture_arb_if #(.COUNTER_NUM(CN)) rec_if ();

    counter_capture_arb #(.COUNTER_NUM(CN)) dut (
        .i_pclk           (i_pclk),
        .i_prst_n         (i_prst_n),
        .i_arb_en         (i_arb_en),
        .i_slot_mask      (i_slot_mask),
        .i_capture_status (i_capture_status),
        .i_capture_data   (i_capture_data),
        .o_read_flag      (o_read_flag),
        .o_busy           (o_busy),
        .rec_if           (rec_if)
    );

    initial i_pclk = 1'b0;
    always #5 i_pclk = ~i_pclk;

    task automatic tick();
        @(posedge i_pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_rec(input string tag, input logic [RN-1:0] flag, input int idx,
                           input int slot, input logic [31:0] data);
        chk({tag, " flag"},  64'(o_read_flag), 64'(flag));
        chk({tag, " valid"}, 64'(rec_if.rec_valid), 64'd1);
        chk({tag, " idx"},   64'(rec_if.rec_cnt_idx), 64'(idx));
        chk({tag, " slot"},  64'(rec_if.rec_slot), 64'(slot));
        chk({tag, " data"},  64'(rec_if.rec_data), 64'(data));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 64'(rec_if.rec_valid), 64'd0);
        chk({tag, " flag"},  64'(o_read_flag), 64'd0);
    endtask

    function automatic logic [31:0] dval(input int k);
        return 32'hD000_0000 | 32'(k);
    endfunction

    function automatic logic [RN-1:0] bit_of(input int k);
        logic [RN-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        i_prst_n         = 1'b0;
        i_arb_en         = 1'b1;
        i_slot_mask      = '1;
        i_capture_status = '0;
        rec_if.rec_ready = 1'b1;
        for (int k = 0; k < RN; k++) i_capture_data[k*32 +: 32] = dval(k);
        i_capture_data[8*32 +: 32] = 32'h1234_5678;

        // reset values
        tick(); tick();
        chk_idle("rst");
        chk("rst idx",  64'(rec_if.rec_cnt_idx), 64'd0);
        chk("rst slot", 64'(rec_if.rec_slot), 64'd0);
        chk("rst data", 64'(rec_if.rec_data), 64'd0);
        chk("rst busy", 64'(o_busy), 64'd0);
        i_prst_n = 1'b1;
        tick();

        // single capture on counter 1 slot a2
        i_capture_status[8] = 1'b1;
        tick();
        chk_rec("t1", bit_of(8), 1, 2, 32'h1234_5678);
        chk("t1 busy", 64'(o_busy), 64'd1);
        tick();
        chk_idle("t1 done");
        chk("t1 busy blocked", 64'(o_busy), 64'd1);
        i_capture_status[8] = 1'b0;
        tick();
        chk("t1 busy clear", 64'(o_busy), 64'd0);
        chk_idle("t1 no regrant");

        // round-robin order from ptr=0 after a fresh reset
        i_prst_n = 1'b0;
        tick();
        i_prst_n = 1'b1;
        i_capture_status = bit_of(0) | bit_of(7) | bit_of(23);
        tick();
        chk_rec("rr g0", bit_of(0), 0, 0, dval(0));
        tick();
        chk_idle("rr x0");
        tick();
        chk_rec("rr g7", bit_of(7), 1, 1, dval(7));
        i_capture_status[0] = 1'b0;
        tick();
        tick();
        chk_rec("rr g23", bit_of(23), 3, 5, dval(23));
        i_capture_status[7] = 1'b0;
        tick();
        i_capture_status[23] = 1'b0;
        tick();
        chk_idle("rr drained");
        i_capture_status = bit_of(0) | bit_of(23);
        tick();
        chk_rec("rr wrap g0", bit_of(0), 0, 0, dval(0));
        tick();
        tick();
        chk_rec("rr wrap g23", bit_of(23), 3, 5, dval(23));
        i_capture_status = '0;
        tick();
        tick();

        // consumer stalls for 10 cycles
        rec_if.rec_ready = 1'b0;
        i_capture_status[12] = 1'b1;
        tick();
        chk_rec("stall g12", bit_of(12), 2, 0, dval(12));
        i_capture_status[13] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk_rec("stall hold", '0, 2, 0, dval(12));
        end
        rec_if.rec_ready = 1'b1;
        tick();
        chk_idle("stall xfer");
        tick();
        chk_rec("stall g13", bit_of(13), 2, 1, dval(13));
        i_capture_status = '0;
        tick();
        tick();

        // status held high after read blocks a regrant
        i_capture_status[5] = 1'b1;
        tick();
        chk_rec("blk g5", bit_of(5), 0, 5, dval(5));
        tick();
        for (int n = 0; n < 4; n++) begin
            tick();
            chk_idle("blk held");
        end
        i_capture_status[5] = 1'b0;
        tick();
        chk("blk busy", 64'(o_busy), 64'd0);
        i_capture_status[5] = 1'b1;
        tick();
        chk_rec("blk regrant", bit_of(5), 0, 5, dval(5));
        tick();
        i_capture_status = '0;
        tick();

        // masked slot never granted; disable during HOLD completes the record
        i_slot_mask[3] = 1'b0;
        i_capture_status[3] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk_idle("mask");
            chk("mask busy", 64'(o_busy), 64'd0);
        end
        rec_if.rec_ready = 1'b0;
        i_capture_status[10] = 1'b1;
        tick();
        chk_rec("en g10", bit_of(10), 1, 4, dval(10));
        tick();
        i_arb_en = 1'b0;
        tick();
        tick();
        chk_rec("en hold", '0, 1, 4, dval(10));
        rec_if.rec_ready = 1'b1;
        tick();
        chk_idle("en xfer");
        i_capture_status[10] = 1'b0;
        i_capture_status[11] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk_idle("en off");
        end
        i_arb_en = 1'b1;
        tick();
        chk_rec("en g11", bit_of(11), 1, 5, dval(11));
        i_capture_status = '0;
        i_slot_mask = '1;
        tick();
        tick();

        // reset while a record is held
        rec_if.rec_ready = 1'b0;
        i_capture_status[2] = 1'b1;
        tick();
        chk_rec("hrst g2", bit_of(2), 0, 2, dval(2));
        i_prst_n = 1'b0;
        #1;
        chk_idle("hrst async");
        chk("hrst slot", 64'(rec_if.rec_slot), 64'd0);
        chk("hrst data", 64'(rec_if.rec_data), 64'd0);
        chk("hrst busy", 64'(o_busy), 64'd0);
        tick();
        i_arb_en = 1'b0;
        i_prst_n = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        chk_idle("hrst quiet");
        i_arb_en = 1'b1;
        tick();
        chk_rec("hrst g2 again", bit_of(2), 0, 2, dval(2));
`ifdef COUNTER_CAPARB_TIMESTAMP_EN
        chk("hrst ts", 64'(rec_if.rec_timestamp), 64'd5);
`endif
        rec_if.rec_ready = 1'b1;
        tick();
        chk_idle("end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_capture_arb.md
# counter_capture_arb

Round-robin scheduler that drains pending capture registers from the counter array. Scans the capture-status bits of all counters, grants one pending capture at a time, pulses that counter's capture read flag, and presents the captured value as a record on a valid/ready stream toward the register-readback/DMA logic. Sits in the APB register clock domain beside the counter array, driving its `i_capture_reg_read_flag` bus.

## Interface
- `COUNTER_NUM`, 4, number of counters served; REQ_NUM = COUNTER_NUM*6 requesters
- `IDX_W`, max(1,$clog2(COUNTER_NUM)), local, counter index width
- `i_pclk` in 1: clock
- `i_prst_n` in 1: reset, asynchronous, active-low
- `i_arb_en` in 1: 1 = scheduling enabled
- `i_slot_mask` in COUNTER_NUM*6: 1 = slot eligible; bit map per counter as `i_capture_reg_status`
- `i_capture_status` in COUNTER_NUM*6: capture-valid bits from counters; per counter bit0..5 = a0,a1,a2,b0,b1,b2
- `i_capture_data` in COUNTER_NUM*6*32: captured values; slot s of counter c at bits [(c*6+s)*32 +: 32]
- `o_read_flag` out COUNTER_NUM*6: one-cycle read acknowledge per slot
- `o_rec_valid` out 1: record valid
- `i_rec_ready` in 1: record consumer ready
- `o_rec_cnt_idx` out IDX_W: counter index of record
- `o_rec_slot` out 3: slot 0..5
- `o_rec_data` out 32: captured value
- `o_busy` out 1: record held or any slot blocked
- `o_rec_timestamp` out 32: only with macro (see Configuration)

## Operation
- req = i_capture_status & i_slot_mask & ~blocked; flat index k = c*6+s.
- States: IDLE, HOLD.
- IDLE: if i_arb_en and |req: grant first set req bit at or after ptr, wrapping at REQ_NUM-1 -> 0; latch cnt_idx=k/6, slot=k%6, data=i_capture_data[k]; pulse o_read_flag[k]; set blocked[k]; ptr <= k+1 (wraps to 0); -> HOLD. Otherwise stay.
- HOLD: o_rec_valid=1, record fields stable; on i_rec_ready -> IDLE.
- blocked[k] clears in any cycle where i_capture_status[k]=0; prevents re-grant before the counter clears its status. Set wins over clear in the grant cycle.
- i_arb_en deassert: no new grants; a held record completes normally.
- i_slot_mask change affects only subsequent grants.
- Reset mid-HOLD: record dropped, no further read flag; blocked cleared.

## Timing
- Reset values: o_read_flag=0, o_rec_valid=0, o_rec_cnt_idx=0, o_rec_slot=0, o_rec_data=0, o_busy=0, o_rec_timestamp=0, ptr=0, state IDLE.
- All outputs registered.
- req seen in IDLE at cycle n -> o_read_flag[k] high in cycle n+1 only; o_rec_valid high from n+1.
- Transfer when o_rec_valid & i_rec_ready; next grant decided in the following IDLE cycle, so earliest next o_rec_valid is 2 cycles after transfer (max throughput 1 record / 2 cycles).
- o_rec_valid never drops without a transfer, except on reset.

## Configuration
- `COUNTER_CAPARB_TIMESTAMP_EN` defined: 32-bit free-running counter, reset 0, +1 each cycle, wraps 0xFFFF_FFFF->0; value latched into o_rec_timestamp at grant.
- Not defined: no timestamp counter, o_rec_timestamp port absent.

## Structure
- Shared `counter_pkg`: slot encodings (SLOT_A0=0..SLOT_B2=5), SLOTS_PER_CNT=6, DATA_W=32, state enum.
- Sub-module `counter_rr_arb`: combinational round-robin pick over REQ_NUM bits given ptr, outputs grant index and any-grant.

## Test plan
- COUNTER_NUM=4, status bit 8 (c1,a2) set, data 0x1234_5678, ready=1 -> 1 cycle later read_flag bit 8 pulse, record idx=1, slot=2, data=0x1234_5678.
- Status bits 0, 7, 23 all set and held until cleared 2 cycles after read flag -> grants in order 0, 7, 23; then with ptr=0 bits 23, 0 set -> 0 before 23.
- Ready held 0 for 10 cycles -> valid and fields stable 10 cycles, single read_flag pulse, no new grant.
- Status bit 5 held high 5 cycles after read flag -> no regrant until it drops; re-set afterwards -> granted again.
- Mask bit 3=0 with status bit 3 set -> never granted; arb_en=0 during HOLD -> current record completes, no further grants.
- Reset asserted in HOLD -> all outputs 0 immediately; with macro, timestamp at first grant after reset equals cycles since reset release.
